// File: rtl/irq_controller_if.sv
// Interrupt-side bundle between peripherals/CSR/core and the irq_controller.
// slave = the controller, master = the core/CSR/peripheral side driving it.
interface irq_controller_if;
  logic [5:0]  irq_i;
  logic [5:0]  mie_i;
  logic        int_ack_i;
  logic        mret_i;
  logic        int_o;
  logic [31:0] mcause_o;
  logic [5:0]  irq_ret_o;
  logic        busy_o;

  modport slave (
    input  irq_i, mie_i, int_ack_i, mret_i,
    output int_o, mcause_o, irq_ret_o, busy_o
  );

  modport master (
    output irq_i, mie_i, int_ack_i, mret_i,
    input  int_o, mcause_o, irq_ret_o, busy_o
  );
endinterface

// File: rtl/irq_controller.sv
// Six-source fixed-priority machine interrupt controller: request, ack, mret completion.
// IRQ_EDGE_DETECT_EN selects edge-latched pending sources; default build is level-triggered.
module irq_controller (
  input  logic              clk,
  input  logic              rst_n,
  irq_controller_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t      state;
  logic [5:0]  pend;
  logic [5:0]  eligible;
  logic [2:0]  win;
  logic [2:0]  idx;
  logic        int_q;
  logic [31:0] mcause_q;
  logic [5:0]  irq_ret_q;
  logic        busy_q;

`ifdef IRQ_EDGE_DETECT_EN
  logic [5:0] irq_q;
  logic [5:0] pend_q;
  logic [5:0] pend_clr;

  always_comb begin
    pend_clr = '0;
    if (state == REQ && bus.int_ack_i) pend_clr[idx] = 1'b1;
  end

  // A fresh rising edge overrides a same-cycle ack clear so the event is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= bus.irq_i;
      pend_q <= (pend_q & ~pend_clr) | (bus.irq_i & ~irq_q);
    end
  end

  assign pend = pend_q;
`else
  assign pend = bus.irq_i;
`endif

  assign eligible = pend & bus.mie_i;

  // Lowest set index wins.
  always_comb begin
    win = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (eligible[i]) win = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      int_q     <= 1'b0;
      mcause_q  <= '0;
      irq_ret_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      irq_ret_q <= '0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            idx      <= win;
            mcause_q <= 32'h8000_0010 + {29'd0, win};
            int_q    <= 1'b1;
            busy_q   <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus.int_ack_i) begin
            int_q <= 1'b0;
            state <= SERVICE;
          end
        end
        SERVICE: begin
          if (bus.mret_i) begin
            irq_ret_q[idx] <= 1'b1;
            busy_q         <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          int_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.int_o     = int_q;
  assign bus.mcause_o  = mcause_q;
  assign bus.irq_ret_o = irq_ret_q;
  assign bus.busy_o    = busy_q;

endmodule
